// File: rtl/hammu_axi_master.sv
// AXI4-Lite master that sequences one X^A job through hammu_ip:
// write X, write A, set START, poll DONE, read P, clear START, then report.
module hammu_axi_master #(
   parameter logic [31:0] BASE_ADDR  = 32'h7c800000,
   parameter int          POLL_LIMIT = 1024
) (
   input  logic        M_AXI_ACLK,
   input  logic        M_AXI_ARESET,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [31:0] job_x,
   input  logic [31:0] job_a,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_p,
   output logic        res_err,
   output logic        busy,
   output logic [31:0] M_AXI_AWADDR,
   output logic        M_AXI_AWVALID,
   input  logic        M_AXI_AWREADY,
   output logic [31:0] M_AXI_WDATA,
   output logic [3:0]  M_AXI_WSTRB,
   output logic        M_AXI_WVALID,
   input  logic        M_AXI_WREADY,
   input  logic [1:0]  M_AXI_BRESP,
   input  logic        M_AXI_BVALID,
   output logic        M_AXI_BREADY,
   output logic [31:0] M_AXI_ARADDR,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY
);
   localparam int CW = $clog2(POLL_LIMIT + 1);

   typedef enum logic [2:0] {IDLE, WR_X, WR_A, WR_GO, RD_DONE, RD_P, WR_CLR, RESP} state_t;

   state_t        r_state;
   logic [31:0]   r_x, r_a;
   logic [CW-1:0] r_poll;
   logic          r_issued, r_aw_done, r_w_done, r_ar_done;
   logic          r_job_ready, r_busy, r_res_valid, r_res_err;
   logic [31:0]   r_res_p, r_awaddr, r_wdata, r_araddr;
   logic [3:0]    r_wstrb;
   logic          r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;

   logic [31:0]   w_wr_addr, w_wr_data, w_rd_addr;
   logic [CW-1:0] w_poll_nxt;
   logic          w_aw_hs, w_w_hs, w_ar_hs;

   assign w_aw_hs    = r_awvalid & M_AXI_AWREADY;
   assign w_w_hs     = r_wvalid & M_AXI_WREADY;
   assign w_ar_hs    = r_arvalid & M_AXI_ARREADY;
   assign w_poll_nxt = r_poll + CW'(1);

   always_comb begin
      w_wr_addr = BASE_ADDR;
      w_wr_data = r_x;
      case (r_state)
         WR_A:    begin w_wr_addr = BASE_ADDR + 32'h4; w_wr_data = r_a;   end
         WR_GO:   begin w_wr_addr = BASE_ADDR + 32'h8; w_wr_data = 32'd1; end
         WR_CLR:  begin w_wr_addr = BASE_ADDR + 32'h8; w_wr_data = 32'd0; end
         default: ;
      endcase
      w_rd_addr = (r_state == RD_P) ? BASE_ADDR + 32'hC : BASE_ADDR + 32'h10;
   end

   // r_issued splits every state into an issue cycle and a wait-for-response phase
   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_a         <= '0;
         r_poll      <= '0;
         r_issued    <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_ar_done   <= 1'b0;
         r_job_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_err   <= 1'b0;
         r_res_p     <= '0;
         r_awaddr    <= '0;
         r_wdata     <= '0;
         r_araddr    <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
      end else begin
         if (w_aw_hs) begin r_awvalid <= 1'b0; r_aw_done <= 1'b1; end
         if (w_w_hs)  begin r_wvalid  <= 1'b0; r_w_done  <= 1'b1; end
         if (w_ar_hs) begin r_arvalid <= 1'b0; r_ar_done <= 1'b1; end

         case (r_state)
            IDLE: begin
               r_job_ready <= 1'b1;
               if (job_valid && r_job_ready) begin
                  r_job_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_x         <= job_x;
                  r_a         <= job_a;
                  r_poll      <= '0;
                  r_res_p     <= '0;
                  r_res_err   <= 1'b0;
                  r_issued    <= 1'b0;
                  r_state     <= WR_X;
               end
            end
            WR_X, WR_A, WR_GO, WR_CLR: begin
               if (!r_issued) begin
                  r_issued  <= 1'b1;
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_bready  <= 1'b1;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_awaddr  <= w_wr_addr;
                  r_wdata   <= w_wr_data;
                  r_wstrb   <= 4'hF;
               end else if (r_aw_done && r_w_done && M_AXI_BVALID) begin
                  r_bready <= 1'b0;
                  r_issued <= 1'b0;
                  if (M_AXI_BRESP != 2'b00) begin
                     r_res_err <= 1'b1;
                     r_res_p   <= '0;
                     r_state   <= RESP;
                  end else begin
                     case (r_state)
                        WR_X:    r_state <= WR_A;
                        WR_A:    r_state <= WR_GO;
                        WR_GO:   r_state <= RD_DONE;
                        default: r_state <= RESP;
                     endcase
                  end
               end
            end
            RD_DONE, RD_P: begin
               if (!r_issued) begin
                  r_issued  <= 1'b1;
                  r_arvalid <= 1'b1;
                  r_rready  <= 1'b1;
                  r_ar_done <= 1'b0;
                  r_araddr  <= w_rd_addr;
               end else if (r_ar_done && r_rready && M_AXI_RVALID) begin
                  r_rready <= 1'b0;
                  r_issued <= 1'b0;
                  if (M_AXI_RRESP != 2'b00) begin
                     r_res_err <= 1'b1;
                     r_res_p   <= '0;
                     r_state   <= RESP;
                  end else if (r_state == RD_P) begin
                     r_res_p <= M_AXI_RDATA;
                     r_state <= WR_CLR;
                  end else begin
                     r_poll <= w_poll_nxt;
                     if (M_AXI_RDATA[0]) begin
                        r_state <= RD_P;
                     end else if (w_poll_nxt == CW'(POLL_LIMIT)) begin
                        // START must still be cleared after a timeout
                        r_res_err <= 1'b1;
                        r_res_p   <= '0;
                        r_state   <= WR_CLR;
                     end
                  end
               end
            end
            RESP: begin
               if (!r_issued) begin
                  r_issued    <= 1'b1;
                  r_res_valid <= 1'b1;
               end else if (r_res_valid && res_ready) begin
                  r_res_valid <= 1'b0;
                  r_issued    <= 1'b0;
                  r_busy      <= 1'b0;
                  r_job_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign job_ready     = r_job_ready;
   assign busy          = r_busy;
   assign res_valid     = r_res_valid;
   assign res_p         = r_res_p;
   assign res_err       = r_res_err;
   assign M_AXI_AWADDR  = r_awaddr;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_WDATA   = r_wdata;
   assign M_AXI_WSTRB   = r_wstrb;
   assign M_AXI_WVALID  = r_wvalid;
   assign M_AXI_BREADY  = r_bready;
   assign M_AXI_ARADDR  = r_araddr;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_RREADY  = r_rready;
endmodule
